multi_fifo_rr_merge: RTL and testbench
======================================

// Module: multi_fifo_rr_merge
// PURPOSE
//   NUM_FIFOS independent write-side FIFOs merged onto a single output stream by a
//   round-robin arbiter with a valid/ready handshake. Adds per-channel occupancy,
//   almost-full and sticky overflow reporting. Sits between per-source producers and
//   one shared downstream consumer.
// PARAMETERS
//   DATA_WIDTH  8   width of each channel word
//   FIFO_DEPTH  16  entries per channel FIFO; power of two, >= 2
//   NUM_FIFOS   4   number of channels, >= 2
//   AF_THRESH   12  ALMOST_FULL[i] asserts when LEVEL[i] >= AF_THRESH; 1..FIFO_DEPTH
// PORTS
//   CLK          in   1                     system clock
//   RST_N        in   1                     asynchronous active-low reset
//   WR_EN        in   NUM_FIFOS             per-channel write strobe
//   DIN          in   NUM_FIFOS*DATA_WIDTH  channel i data on DIN[i*DW +: DW]
//   ERR_CLR      in   1                     clears all OVERFLOW flags
//   OUT_READY    in   1                     consumer ready
//   OUT_VALID    out  1                     OUT_DATA/OUT_CH hold a valid word
//   OUT_DATA     out  DATA_WIDTH            merged output word
//   OUT_CH       out  max(1,$clog2(NUM_FIFOS))  source channel of OUT_DATA
//   FULL         out  NUM_FIFOS             channel FIFO holds FIFO_DEPTH entries
//   EMPTY        out  NUM_FIFOS             channel FIFO holds 0 entries
//   ALMOST_FULL  out  NUM_FIFOS             LEVEL[i] >= AF_THRESH
//   LEVEL        out  NUM_FIFOS*($clog2(FIFO_DEPTH)+1)  per-channel entry count
//   OVERFLOW     out  NUM_FIFOS             sticky: write attempted while FULL
// BEHAVIOUR
//   Reset (async, RST_N=0): pointers/LEVEL=0, EMPTY=all 1, FULL/ALMOST_FULL=0,
//     OVERFLOW=0, OUT_VALID=0, OUT_DATA=0, OUT_CH=0, RR last-grant=NUM_FIFOS-1.
//     Reset mid-operation discards all stored and output-staged data.
//   Write: WR_EN[i]=1 & FULL[i]=0 at edge t -> entry stored; LEVEL/EMPTY/FULL update
//     at t+1. FULL/LEVEL are registered: a same-cycle pop does NOT admit a write to a
//     full channel. WR_EN[i] while FULL[i] -> word dropped, OVERFLOW[i]<=1.
//   Output stage: one register slot. Slot free = !OUT_VALID | (OUT_VALID & OUT_READY).
//     When slot free and any EMPTY[i]=0, arbiter grants the first non-empty channel
//     searching from (last_grant+1) mod NUM_FIFOS upward with wrap; granted FIFO pops,
//     slot loads next edge (OUT_VALID=1, OUT_DATA, OUT_CH), last_grant<=granted ch.
//     No non-empty channel and slot consumed -> OUT_VALID<=0; OUT_DATA/OUT_CH hold.
//   Latency: write at edge t into empty system -> OUT_VALID at edge t+2.
//   Throughput: one word/cycle with OUT_READY=1 continuously.
//   Handshake: transfer when OUT_VALID & OUT_READY. While OUT_VALID=1 & OUT_READY=0,
//     OUT_DATA/OUT_CH stable and no pop occurs. OUT_VALID never drops without transfer.
//   Simultaneous write+pop same channel: both occur; LEVEL unchanged.
//   Pointers wrap modulo FIFO_DEPTH; LEVEL range 0..FIFO_DEPTH, one extra bit.
//   ERR_CLR: OVERFLOW<=0 for all channels; a new overflow in the same cycle wins (sets).
//   Per-channel order preserved; no word duplicated or lost except dropped overflow writes.
// TESTING
//   1 Reset: RST_N=0 any time -> immediately EMPTY=4'hF, FULL=0, LEVEL=0, OUT_VALID=0.
//   2 OUT_READY=1, WR_EN=4'b0100, DIN[23:16]=8'hA5 at edge t -> edge t+2 OUT_VALID=1,
//     OUT_DATA=8'hA5, OUT_CH=2; edge t+3 OUT_VALID=0.
//   3 OUT_READY=0, 18 consecutive writes to ch0 -> word0 staged, LEVEL[0]=16, FULL[0]=1,
//     ALMOST_FULL[0]=1, OVERFLOW[0]=1, word17 never emerges; ERR_CLR -> OVERFLOW[0]=0.
//   4 All 4 channels preloaded with 3 words, OUT_READY=1 -> OUT_CH sequence
//     0,1,2,3,0,1,2,3,0,1,2,3 on 12 consecutive cycles, per-channel data in order.
//   5 OUT_VALID=1, OUT_READY=0 for 5 cycles with writes ongoing -> OUT_DATA/OUT_CH
//     constant; first word after OUT_READY=1 comes from next RR channel.
//   6 Reset asserted mid-stream with all channels non-empty -> post-reset no stale word
//     appears; first new write returns with OUT_CH of that channel at t+2.

Source files
------------

// File: rtl/multi_fifo_rr_merge.sv
// multi_fifo_rr_merge: NUM_FIFOS write-side FIFOs merged round-robin onto one
// valid/ready stream; per-channel LEVEL/FULL/EMPTY/ALMOST_FULL and sticky OVERFLOW.
module multi_fifo_rr_merge #(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int NUM_FIFOS  = 4,
  parameter  int AF_THRESH  = 12,
  localparam int CW = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [NUM_FIFOS-1:0]          WR_EN,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] DIN,
  input  logic                          ERR_CLR,
  input  logic                          OUT_READY,
  output logic                          OUT_VALID,
  output logic [DATA_WIDTH-1:0]         OUT_DATA,
  output logic [CW-1:0]                 OUT_CH,
  output logic [NUM_FIFOS-1:0]          FULL,
  output logic [NUM_FIFOS-1:0]          EMPTY,
  output logic [NUM_FIFOS-1:0]          ALMOST_FULL,
  output logic [NUM_FIFOS*LW-1:0]       LEVEL,
  output logic [NUM_FIFOS-1:0]          OVERFLOW
);

  localparam int PW = LW - 1;

  logic [DATA_WIDTH-1:0] mem [NUM_FIFOS][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] head [NUM_FIFOS];
  logic [PW-1:0]         wr_ptr [NUM_FIFOS];
  logic [PW-1:0]         rd_ptr [NUM_FIFOS];
  logic [LW-1:0]         lvl [NUM_FIFOS];

  logic [NUM_FIFOS-1:0]  push;
  logic [NUM_FIFOS-1:0]  pop;
  logic [NUM_FIFOS-1:0]  full;
  logic [NUM_FIFOS-1:0]  empty;
  logic [NUM_FIFOS-1:0]  ovf;

  logic [CW-1:0]         last_grant;
  logic [CW-1:0]         grant_ch;
  logic                  grant_vld;
  logic                  slot_free;
  logic [CW:0]           cand;

  assign slot_free   = ~OUT_VALID | OUT_READY;
  assign FULL        = full;
  assign EMPTY       = empty;
  assign OVERFLOW    = ovf;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_ch
    assign full[g]        = lvl[g] == LW'(FIFO_DEPTH);
    assign empty[g]       = lvl[g] == '0;
    assign ALMOST_FULL[g] = lvl[g] >= LW'(AF_THRESH);
    // FULL is registered: a pop in this cycle does not free room
    assign push[g]        = WR_EN[g] & ~full[g];
    assign pop[g]         = grant_vld & slot_free
                          & (grant_ch == CW'(g));
    assign head[g]        = mem[g][rd_ptr[g]];
    assign LEVEL[g*LW +: LW] = lvl[g];

    always_ff @(posedge CLK) begin
      if (push[g])
        mem[g][wr_ptr[g]] <= DIN[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        wr_ptr[g] <= '0;
        rd_ptr[g] <= '0;
        lvl[g]    <= '0;
      end else begin
        if (push[g])
          wr_ptr[g] <= wr_ptr[g] + PW'(1);
        if (pop[g])
          rd_ptr[g] <= rd_ptr[g] + PW'(1);
        unique case ({push[g], pop[g]})
          2'b10:   lvl[g] <= lvl[g] + LW'(1);
          2'b01:   lvl[g] <= lvl[g] - LW'(1);
          default: lvl[g] <= lvl[g];
        endcase
      end
    end

    // a fresh overflow outranks a clear in the same cycle
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
        ovf[g] <= 1'b0;
      else if (WR_EN[g] & full[g])
        ovf[g] <= 1'b1;
      else if (ERR_CLR)
        ovf[g] <= 1'b0;
    end
  end

  // first non-empty channel after last_grant, wrapping
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = last_grant;
    cand      = '0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = {1'b0, last_grant} + (CW+1)'(k);
      if (cand >= (CW+1)'(NUM_FIFOS))
        cand = cand - (CW+1)'(NUM_FIFOS);
      if (!grant_vld && !empty[cand[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = cand[CW-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID  <= 1'b0;
      OUT_DATA   <= '0;
      OUT_CH     <= '0;
      last_grant <= CW'(NUM_FIFOS - 1);
    end else if (grant_vld & slot_free) begin
      OUT_VALID  <= 1'b1;
      OUT_DATA   <= head[grant_ch];
      OUT_CH     <= grant_ch;
      last_grant <= grant_ch;
    end else if (OUT_READY) begin
      OUT_VALID  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_fifo_rr_merge.sv
// tb_multi_fifo_rr_merge: directed scenarios plus random traffic checked
// against a queue-based reference model of the merge.
module tb_multi_fifo_rr_merge;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int LW    = 5;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [3:0]    WR_EN = '0;
  logic [31:0]   DIN = '0;
  logic          ERR_CLR = 1'b0;
  logic          OUT_READY = 1'b0;
  logic          OUT_VALID;
  logic [7:0]    OUT_DATA;
  logic [1:0]    OUT_CH;
  logic [3:0]    FULL;
  logic [3:0]    EMPTY;
  logic [3:0]    ALMOST_FULL;
  logic [19:0]   LEVEL;
  logic [3:0]    OVERFLOW;

  int n_cmp = 0;
  int n_err = 0;

  multi_fifo_rr_merge dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .DIN(DIN),
    .ERR_CLR(ERR_CLR), .OUT_READY(OUT_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH),
    .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .LEVEL(LEVEL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // reference model: a queue per channel plus one output slot
  logic [7:0] mq [N][$];
  logic       m_v;
  logic [7:0] m_d;
  int         m_ch;
  int         m_lg;
  logic [3:0] m_ovf;

  always @(posedge CLK or negedge RST_N) begin : model
    int g;
    bit fullpre [N];
    if (!RST_N) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_v = 1'b0; m_d = '0; m_ch = 0; m_lg = N - 1; m_ovf = '0;
    end else begin
      for (int i = 0; i < N; i++) fullpre[i] = (mq[i].size() == DEPTH);
      g = -1;
      if (!m_v || OUT_READY)
        for (int k = 1; k <= N; k++)
          if (g < 0 && mq[(m_lg + k) % N].size() != 0) g = (m_lg + k) % N;
      if (g >= 0) begin
        m_d = mq[g].pop_front(); m_v = 1'b1; m_ch = g; m_lg = g;
      end else if (OUT_READY) begin
        m_v = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (WR_EN[i] && fullpre[i]) m_ovf[i] = 1'b1;
        else begin
          if (ERR_CLR) m_ovf[i] = 1'b0;
          if (WR_EN[i]) mq[i].push_back(DIN[i*8 +: 8]);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0; WR_EN = '0; ERR_CLR = 1'b0; OUT_READY = 1'b0; DIN = '0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int w = 0; w < 3; w++) begin
      @(negedge CLK);
      WR_EN = 4'hF; DIN = $urandom;
    end
    @(negedge CLK);
    WR_EN = '0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (EMPTY !== 4'hF) begin
      n_err++; $display("FAIL reset_empty: got %h want f", EMPTY);
    end
    n_cmp++;
    if (FULL !== 4'h0 || ALMOST_FULL !== 4'h0 || OVERFLOW !== 4'h0) begin
      n_err++;
      $display("FAIL reset_flags: full %h af %h ovf %h want 0", FULL, ALMOST_FULL, OVERFLOW);
    end
    n_cmp++;
    if (LEVEL !== 20'h0) begin
      n_err++; $display("FAIL reset_level: got %h want 0", LEVEL);
    end
    n_cmp++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h0 || OUT_CH !== 2'd0) begin
      n_err++;
      $display("FAIL reset_out: v %b d %h ch %0d want 0/0/0", OUT_VALID, OUT_DATA, OUT_CH);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_latency();
    apply_reset();
    @(negedge CLK);
    OUT_READY = 1'b1; WR_EN = 4'b0100; DIN = '0; DIN[23:16] = 8'hA5;
    @(negedge CLK);
    WR_EN = '0;
    n_cmp++;
    if (OUT_VALID !== 1'b0 || LEVEL[2*LW +: LW] !== 5'd1) begin
      n_err++;
      $display("FAIL lat_t1: v %b lvl %0d want 0/1", OUT_VALID, LEVEL[2*LW +: LW]);
    end
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA5 || OUT_CH !== 2'd2) begin
      n_err++;
      $display("FAIL lat_t2: v %b d %h ch %0d want 1/a5/2", OUT_VALID, OUT_DATA, OUT_CH);
    end
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_err++; $display("FAIL lat_t3: v %b want 0", OUT_VALID);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got [$];
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      WR_EN = 4'b0001; DIN = '0; DIN[7:0] = 8'(8'h40 + i);
    end
    @(negedge CLK);
    WR_EN = '0;
    n_cmp++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h40) begin
      n_err++; $display("FAIL ovf_staged: v %b d %h want 1/40", OUT_VALID, OUT_DATA);
    end
    n_cmp++;
    if (LEVEL[LW-1:0] !== 5'd16) begin
      n_err++; $display("FAIL ovf_level: got %0d want 16", LEVEL[LW-1:0]);
    end
    n_cmp++;
    if (FULL !== 4'b0001 || ALMOST_FULL !== 4'b0001 || OVERFLOW !== 4'b0001) begin
      n_err++;
      $display("FAIL ovf_flags: full %b af %b ovf %b want 0001", FULL, ALMOST_FULL, OVERFLOW);
    end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    n_cmp++;
    if (OVERFLOW !== 4'b0000) begin
      n_err++; $display("FAIL ovf_clear: got %b want 0000", OVERFLOW);
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (OUT_VALID === 1'b1) got.push_back(OUT_DATA);
      @(negedge CLK);
    end
    n_cmp++;
    if (got.size() != 17) begin
      n_err++; $display("FAIL ovf_drain_count: got %0d want 17", got.size());
    end
    for (int i = 0; i < got.size() && i < 17; i++) begin
      n_cmp++;
      if (got[i] !== 8'(8'h40 + i)) begin
        n_err++; $display("FAIL ovf_drain_word%0d: got %h want %h", i, got[i], 8'(8'h40 + i));
      end
    end
  endtask

  task automatic test_rr_order();
    apply_reset();
    for (int w = 0; w < 3; w++) begin
      @(negedge CLK);
      WR_EN = 4'hF;
      for (int c = 0; c < N; c++) DIN[c*8 +: 8] = 8'(c*16 + w + 1);
    end
    @(negedge CLK);
    WR_EN = '0;
    OUT_READY = 1'b1;
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_CH !== 2'(k % 4)
          || OUT_DATA !== 8'((k % 4)*16 + k/4 + 1)) begin
        n_err++;
        $display("FAIL rr_seq%0d: v %b ch %0d d %h want 1/%0d/%h", k, OUT_VALID,
                 OUT_CH, OUT_DATA, k % 4, 8'((k % 4)*16 + k/4 + 1));
      end
      @(negedge CLK);
    end
    n_cmp++;
    if (OUT_VALID !== 1'b0 || EMPTY !== 4'hF) begin
      n_err++; $display("FAIL rr_drained: v %b empty %h want 0/f", OUT_VALID, EMPTY);
    end
  endtask

  task automatic test_stall();
    logic [7:0] ch2_first;
    apply_reset();
    @(negedge CLK);
    WR_EN = 4'b0010; DIN = '0; DIN[15:8] = 8'h11;
    @(negedge CLK);
    WR_EN = '0;
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_CH !== 2'd1 || OUT_DATA !== 8'h11) begin
        n_err++;
        $display("FAIL stall_hold%0d: v %b ch %0d d %h want 1/1/11", i, OUT_VALID, OUT_CH, OUT_DATA);
      end
      WR_EN = 4'hF; DIN = $urandom;
      if (i == 0) ch2_first = DIN[23:16];
      @(negedge CLK);
    end
    WR_EN = '0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b1 || OUT_CH !== 2'd2 || OUT_DATA !== ch2_first) begin
      n_err++;
      $display("FAIL stall_next: v %b ch %0d d %h want 1/2/%h", OUT_VALID, OUT_CH, OUT_DATA, ch2_first);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      WR_EN = 4'hF; DIN = $urandom;
    end
    @(negedge CLK);
    RST_N = 1'b0; WR_EN = '0;
    #1;
    n_cmp++;
    if (EMPTY !== 4'hF || OUT_VALID !== 1'b0 || LEVEL !== 20'h0) begin
      n_err++;
      $display("FAIL mid_reset: empty %h v %b lvl %h want f/0/0", EMPTY, OUT_VALID, LEVEL);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (OUT_VALID !== 1'b0) begin
        n_err++; $display("FAIL mid_stale%0d: v %b d %h want v=0", i, OUT_VALID, OUT_DATA);
      end
    end
    WR_EN = 4'b1000; DIN = '0; DIN[31:24] = 8'h3C;
    @(negedge CLK);
    WR_EN = '0;
    n_cmp++;
    if (OUT_VALID !== 1'b0) begin
      n_err++; $display("FAIL mid_t1: v %b want 0", OUT_VALID);
    end
    @(negedge CLK);
    n_cmp++;
    if (OUT_VALID !== 1'b1 || OUT_CH !== 2'd3 || OUT_DATA !== 8'h3C) begin
      n_err++;
      $display("FAIL mid_t2: v %b ch %0d d %h want 1/3/3c", OUT_VALID, OUT_CH, OUT_DATA);
    end
  endtask

  task automatic test_random();
    logic [3:0]  e_full, e_empty, e_af;
    logic [19:0] e_lvl;
    apply_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        e_full[i]  = mq[i].size() == DEPTH;
        e_empty[i] = mq[i].size() == 0;
        e_af[i]    = mq[i].size() >= AFT;
        e_lvl[i*LW +: LW] = LW'(mq[i].size());
      end
      n_cmp++;
      if (OUT_VALID !== m_v || OUT_DATA !== m_d || OUT_CH !== 2'(m_ch)) begin
        n_err++;
        $display("FAIL rnd_out@%0d: v %b d %h ch %0d want %b/%h/%0d", cyc,
                 OUT_VALID, OUT_DATA, OUT_CH, m_v, m_d, m_ch);
      end
      n_cmp++;
      if (LEVEL !== e_lvl) begin
        n_err++; $display("FAIL rnd_level@%0d: got %h want %h", cyc, LEVEL, e_lvl);
      end
      n_cmp++;
      if (FULL !== e_full || EMPTY !== e_empty || ALMOST_FULL !== e_af) begin
        n_err++;
        $display("FAIL rnd_flags@%0d: f %b e %b af %b want %b/%b/%b", cyc,
                 FULL, EMPTY, ALMOST_FULL, e_full, e_empty, e_af);
      end
      n_cmp++;
      if (OVERFLOW !== m_ovf) begin
        n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", cyc, OVERFLOW, m_ovf);
      end
      WR_EN = 4'($urandom);
      DIN = $urandom;
      ERR_CLR = ($urandom_range(0, 23) == 0);
      // alternate congested and draining phases to reach full and empty
      if ((cyc / 150) % 2 == 0) OUT_READY = ($urandom_range(0, 7) == 0);
      else OUT_READY = ($urandom_range(0, 7) != 0);
    end
    @(negedge CLK);
    WR_EN = '0; ERR_CLR = 1'b0; OUT_READY = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    test_reset();
    test_latency();
    test_overflow();
    test_rr_order();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
